reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the CPU datapath, successor to the single-write, two-read register file. It provides `NUM_RPORTS` asynchronous read ports and `NUM_WPORTS` synchronous write ports with fixed write priority. Entry 0 is hardwired to zero. A sequential clear engine zeroes the array after reset or on a flush request and reports readiness to the pipeline.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of each entry.
- `ADDR_WIDTH`, 5: address width; `DEPTH` = 2**`ADDR_WIDTH`.
- `NUM_RPORTS`, 2: number of read ports (1..8).
- `NUM_WPORTS`, 2: number of write ports (1..4).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clr`  in  1: soft-clear request; sampled only while `ready`=1.
- `ready`  out  1: 1 = array valid, writes accepted.
- `wen`  in  `NUM_WPORTS`: per-port write enable.
- `waddr`  in  `NUM_WPORTS*ADDR_WIDTH`: port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  `NUM_WPORTS*DATA_WIDTH`: port p occupies slice [p*DATA_WIDTH +: DATA_WIDTH].
- `raddr`  in  `NUM_RPORTS*ADDR_WIDTH`: packed in the same way as `waddr`.
- `rdata`  out  `NUM_RPORTS*DATA_WIDTH`: combinational read data, packed in the same way as `wdata`.

## Operation
- FSM states: CLEAR and READY. `clr_idx` is an `ADDR_WIDTH`-bit counter.
- While `rst`=1: state is CLEAR, `clr_idx`=1, `ready`=0.
- Reset has priority over every other input, including in the middle of a clear; it restarts the clear from index 1.
- In CLEAR (rst=0), each edge performs `mem[clr_idx]`<=0 and increments `clr_idx`.
- When the edge writes index `DEPTH`-1, state moves to READY.
- In CLEAR:
  - `wen` and `clr` are ignored.
  - All `rdata` slices read 0.
  - `ready`=0.
- In READY with `clr`=1: the next state is CLEAR with `clr_idx`=1. Writes presented in that same cycle are dropped.
- In READY with `clr`=0: for each port p with `wen[p]`=1 and `waddr_p`≠0, `mem[waddr_p]`<=`wdata_p`.
- Writes to address 0 are discarded.
- If several ports write the same address in one cycle, the highest-index port wins.
- Reads: `rdata_r` = 0 if `raddr_r`=0, otherwise `mem[raddr_r]`. Ports are independent, and any ports may read the same address.
- Entry 0 is never stored, so reads of it are constant 0.

## Timing
- Reads: zero-latency combinational path from `raddr`/`mem` to `rdata`.
- Writes: visible on `rdata` the cycle after the write edge (without bypass).
- Clear duration: exactly `DEPTH`-1 cycles. `ready` rises on the edge after index `DEPTH`-1 is written (31 cycles for `ADDR_WIDTH`=5).
- `ready` is registered and deasserts on the edge that samples `rst` or an accepted `clr`.
- No handshake on writes. The source must hold `wen` low while `ready`=0; writes made in that state are lost, not queued.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In READY with no accepted `clr`, a read whose nonzero address matches an enabled write in the same cycle returns that write's `wdata` combinationally.
  - Among matching ports, the highest-index one supplies the data.
- Not defined: reads return the pre-write `mem` contents, and the new value appears the following cycle.
- Clear behaviour and `ready` are identical in both builds.

## Structure
- Shared package `reg_file_pkg` holds:
  - the default `DATA_WIDTH` and `ADDR_WIDTH` constants;
  - the state enum (CLEAR, READY);
  - a helper function that computes `DEPTH`.
- Sub-module `reg_file_clr_fsm` owns the state, `clr_idx` and `ready`, and outputs a clear-write strobe and address.
- The top level holds the array, the write-priority logic, the read muxes and the bypass logic.

## Test plan
- Reset clear:
  - Stimulus: assert `rst` for 2 cycles, then release.
  - Required: `ready`=0 for 31 cycles and 1 on the 32nd.
  - Required: reads of addresses 1..31 all return 0, and `rdata` reads 0 throughout the clear.
- Basic write/read:
  - Stimulus: port0 writes 0xDEADBEEF to addr 5.
  - Required: the next cycle, read ports 0 and 1 both at addr 5 return 0xDEADBEEF.
  - Stimulus: a write of 0x1234 to addr 0.
  - Required: addr 0 still reads 0.
- Write collision:
  - Stimulus: port0 writes 0x11 and port1 writes 0x22 to addr 7 in the same cycle.
  - Required: addr 7 reads 0x22.
  - Stimulus: port0 writes 0x33 to addr 8 while port1 writes 0x44 to addr 9.
  - Required: both writes land.
- Bypass:
  - Stimulus: in the same cycle, write 0xA5A5A5A5 to addr 3 and read addr 3.
  - Required with `REGFILE_BYPASS_EN`: returns 0xA5A5A5A5 that cycle.
  - Required without it: returns the old value, then 0xA5A5A5A5 next cycle.
- Soft clear with write:
  - Stimulus: `clr`=1 together with a write of 0x77 to addr 4.
  - Required: the write is dropped, `ready` falls next cycle, returns 31 cycles later, and addr 4 reads 0.
- Reset mid-clear:
  - Stimulus: assert `rst` 10 cycles into a clear.
  - Required: on release, `ready` stays 0 for a full 31 further cycles.
  - Required: `wen` pulses during the clear have no effect.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the multi-port register file:
//   - default entry width and address width
//   - clear-engine state enum (CLEAR, READY)
//   - reg_file_depth(): number of entries for a given address width
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int reg_file_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_mp_if
// Bus bundle of the multi-port register file.
//   clr   : soft-clear request (master -> slave)
//   ready : array valid, writes accepted (slave -> master)
//   wen   : per-port write enable, NUM_WPORTS bits
//   waddr : port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata : port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   raddr : packed like waddr, NUM_RPORTS ports
//   rdata : packed like wdata, combinational read data
//
// Handshake: there is no per-write valid/ready exchange. ready=1 qualifies the
// whole write side: a write (wen[p]=1) or clr is taken on a rising edge only
// when ready=1 on that edge; anything presented while ready=0 is dropped, not
// queued. Reads are always combinational and need no handshake.
// -----------------------------------------------------------------------------
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RPORTS = 2,
  parameter int NUM_WPORTS = 2
);

  logic                             clr;
  logic                             ready;
  logic [NUM_WPORTS-1:0]            wen;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;

  modport master (
    output clr, wen, waddr, wdata, raddr,
    input  ready, rdata
  );

  modport slave (
    input  clr, wen, waddr, wdata, raddr,
    output ready, rdata
  );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// -----------------------------------------------------------------------------
// reg_file_clr_fsm
// Clear engine of the register file. Walks clr_idx from 1 to DEPTH-1 after
// reset or an accepted soft clear, then holds READY.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : soft-clear request, honoured only in READY
//   ready     : registered, 1 while in READY
//   state     : current FSM state (debug visibility)
//   clr_we    : clear-write strobe, zero mem[clr_addr] this edge
//   clr_addr  : clear-write address
//   wr_allow  : user writes may commit this edge (READY, no clr, no rst)
//   rd_valid  : array contents are valid for reads
// -----------------------------------------------------------------------------
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  ready,
  output state_t                state,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  wr_allow,
  output logic                  rd_valid
);

  localparam int DEPTH = reg_file_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [ADDR_WIDTH-1:0] idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= FIRST_IDX;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      ready   <= (state_nxt == READY);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    clr_we    = 1'b0;
    clr_addr  = clr_idx;
    unique case (state)
      CLEAR: begin
        // Entry 0 is never stored, so the walk starts at 1.
        clr_we  = !rst;
        idx_nxt = clr_idx + FIRST_IDX;
        if (clr_idx == LAST_IDX) state_nxt = READY;
      end
      READY: begin
        if (clr) begin
          state_nxt = CLEAR;
          idx_nxt   = FIRST_IDX;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Reset and an accepted clear both drop same-cycle writes.
  assign wr_allow = (state == READY) && !clr && !rst;
  assign rd_valid = (state == READY);

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port register file: NUM_RPORTS combinational read ports,
// NUM_WPORTS synchronous write ports (highest-index port wins on collision),
// entry 0 hardwired to zero, sequential clear after reset or soft clear.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : reg_file_mp_if slave (clr, ready, wen, waddr, wdata, raddr, rdata)
//   dbg_state : clear-engine state for observation
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RPORTS = 2,
  parameter int NUM_WPORTS = 2
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_mp_if.slave   bus,
  output state_t         dbg_state
);

  localparam int DEPTH = reg_file_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_allow;
  logic                  rd_valid;

  reg_file_clr_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .ready    (bus.ready),
    .state    (dbg_state),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .wr_allow (wr_allow),
    .rd_valid (rd_valid)
  );

  // Ports are applied in ascending order so the highest-index port's
  // non-blocking assignment is the one that sticks.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_allow) begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (bus.wen[p] && (bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          mem[bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int r = 0; r < NUM_RPORTS; r++) begin
      if (rd_valid && (bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = mem[bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        // Later ports override earlier ones, matching write priority.
        for (int p = 0; p < NUM_WPORTS; p++) begin
          if (wr_allow && bus.wen[p] &&
              (bus.waddr[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
            bus.rdata[r*DATA_WIDTH +: DATA_WIDTH] = bus.wdata[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Directed bench for reg_file_mp with default parameters (32-bit, 32 entries,
// 2 read ports, 2 write ports). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) bus ();

  reg_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr   = 1'b0;
    bus.wen   = '0;
    bus.waddr = '0;
    bus.wdata = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen[p]             = 1'b1;
    bus.waddr[p*AW +: AW]  = a;
    bus.wdata[p*DW +: DW]  = d;
  endtask

  task automatic set_raddr(input int r, input logic [AW-1:0] a);
    bus.raddr[r*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rdat(input int r);
    return bus.rdata[r*DW +: DW];
  endfunction

  logic [DW-1:0] bypass_exp;

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.raddr = '0;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_state", {31'b0, dbg_state}, {31'b0, CLEAR});
    rst = 1'b0;

    // Clear after reset: ready low for 31 cycles, reads all zero.
    for (int i = 0; i < 31; i++) begin
      set_raddr(0, AW'(i + 1));
      set_raddr(1, AW'(31 - i));
      settle();
      check($sformatf("rstclr_ready_%0d", i), {31'b0, bus.ready}, 32'd0);
      check($sformatf("rstclr_rd0_%0d", i), rdat(0), 32'd0);
      tick();
    end
    check("rstclr_ready_up", {31'b0, bus.ready}, 32'd1);
    check("rstclr_state", {31'b0, dbg_state}, {31'b0, READY});

    for (int a = 1; a < 32; a++) begin
      set_raddr(0, AW'(a));
      set_raddr(1, AW'(32 - a));
      settle();
      check($sformatf("zero_rd0_a%0d", a), rdat(0), 32'd0);
      check($sformatf("zero_rd1_a%0d", a), rdat(1), 32'd0);
    end

    // Basic write / read.
    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle_inputs();
    set_raddr(0, 5'd5);
    set_raddr(1, 5'd5);
    settle();
    check("basic_rd0", rdat(0), 32'hDEADBEEF);
    check("basic_rd1", rdat(1), 32'hDEADBEEF);

    // Address 0 discards writes.
    wr(0, 5'd0, 32'h00001234);
    tick();
    idle_inputs();
    set_raddr(0, 5'd0);
    settle();
    check("addr0_rd", rdat(0), 32'd0);
    check("addr0_keep5", rdat(1), 32'hDEADBEEF);

    // Collision: port 1 wins.
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    tick();
    idle_inputs();
    set_raddr(0, 5'd7);
    settle();
    check("collide_a7", rdat(0), 32'h22);

    // Two independent writes.
    wr(0, 5'd8, 32'h33);
    wr(1, 5'd9, 32'h44);
    tick();
    idle_inputs();
    set_raddr(0, 5'd8);
    set_raddr(1, 5'd9);
    settle();
    check("dual_a8", rdat(0), 32'h33);
    check("dual_a9", rdat(1), 32'h44);

    // Same-cycle write and read of address 3 (previously zero).
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'hA5A5A5A5;
`else
    bypass_exp = 32'h0;
`endif
    set_raddr(0, 5'd3);
    set_raddr(1, 5'd7);
    wr(1, 5'd3, 32'hA5A5A5A5);
    settle();
    check("bypass_same", rdat(0), bypass_exp);
    check("bypass_other", rdat(1), 32'h22);
    tick();
    idle_inputs();
    settle();
    check("bypass_next", rdat(0), 32'hA5A5A5A5);

    // Soft clear with a concurrent write that must be dropped.
    bus.clr = 1'b1;
    wr(0, 5'd4, 32'h77);
    settle();
    check("sclr_ready_pre", {31'b0, bus.ready}, 32'd1);
    tick();
    idle_inputs();
    set_raddr(0, 5'd4);
    set_raddr(1, 5'd5);
    for (int i = 0; i < 31; i++) begin
      settle();
      check($sformatf("sclr_ready_%0d", i), {31'b0, bus.ready}, 32'd0);
      tick();
    end
    check("sclr_ready_up", {31'b0, bus.ready}, 32'd1);
    check("sclr_a4", rdat(0), 32'd0);
    check("sclr_a5", rdat(1), 32'd0);
    set_raddr(0, 5'd3);
    set_raddr(1, 5'd9);
    settle();
    check("sclr_a3", rdat(0), 32'd0);
    check("sclr_a9", rdat(1), 32'd0);

    // Reset in the middle of a clear; writes during clear are lost.
    wr(0, 5'd6, 32'h66);
    tick();
    idle_inputs();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr(0, 5'd20, 32'h00000BAD);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("mid_rst_ready", {31'b0, bus.ready}, 32'd0);
    rst = 1'b0;
    set_raddr(0, 5'd6);
    set_raddr(1, 5'd20);
    for (int i = 0; i < 31; i++) begin
      wr(1, 5'd25, 32'h0000CAFE);
      settle();
      check($sformatf("mid_ready_%0d", i), {31'b0, bus.ready}, 32'd0);
      check($sformatf("mid_rd_%0d", i), rdat(1), 32'd0);
      tick();
    end
    idle_inputs();
    settle();
    check("mid_ready_up", {31'b0, bus.ready}, 32'd1);
    check("mid_a6", rdat(0), 32'd0);
    check("mid_a20", rdat(1), 32'd0);
    set_raddr(0, 5'd25);
    settle();
    check("mid_a25", rdat(0), 32'd0);

    // Writes accepted again once ready.
    wr(0, 5'd31, 32'h13579BDF);
    wr(1, 5'd1, 32'h2468ACE0);
    tick();
    idle_inputs();
    set_raddr(0, 5'd31);
    set_raddr(1, 5'd1);
    settle();
    check("post_a31", rdat(0), 32'h13579BDF);
    check("post_a1", rdat(1), 32'h2468ACE0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
